rcounter_bcd_timer: RTL



---
 rtl/rcounter_pkg.sv | 27 ++
 rtl/rcounter_bcd_timer_if.sv | 28 ++
 rtl/rcounter_bcd_timer_bcd_pair_step.sv | 41 ++++
 rtl/rcounter_bcd_timer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rcounter_pkg.sv
// Shared types, BCD limits and preset validation for the BCD timer.
// No ports; imported by the interface consumers and the counter datapath.
package rcounter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
  localparam logic [3:0] BCD_TENS_SEC_MAX = 4'd5;
  localparam logic [7:0] BCD_SEC_MAX      = 8'h59;
  localparam logic [7:0] BCD_CENT_MAX     = 8'h99;

  // BCD ordering matches numeric ordering once both digits are legal,
  // so a plain compare against a BCD limit is sufficient.
  function automatic logic bcd_pair_valid(
    input logic [7:0] value,
    input logic [7:0] max
  );
    return (value[7:4] <= BCD_DIGIT_MAX) &&
           (value[3:0] <= BCD_DIGIT_MAX) &&
           (value <= max);
  endfunction

endpackage

// File: rtl/rcounter_bcd_timer_if.sv
// Control/preset and time/status bundle between front-end and timer.
// master: button/preset side; slave: the timer core.
interface rcounter_bcd_timer_if;

  logic       load;
  logic       en;
  logic       dir;
  logic [7:0] min_i;
  logic [7:0] sec_i;
  logic [7:0] ms_10_i;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic [7:0] ms_10_o;
  logic       time_out;
  logic       running;
  logic       load_err;

  modport master (
    output load, en, dir, min_i, sec_i, ms_10_i,
    input  min_o, sec_o, ms_10_o, time_out, running, load_err
  );

  modport slave (
    input  load, en, dir, min_i, sec_i, ms_10_i,
    output min_o, sec_o, ms_10_o, time_out, running, load_err
  );

endinterface

// File: rtl/rcounter_bcd_timer_bcd_pair_step.sv
// One two-digit BCD field stepped up/down by one with wrap at 0/MAX.
// Ports: val_i current, step_i/dir_i control, val_o next, cy_o carry/borrow.
module bcd_pair_step
  import rcounter_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic [7:0] val_i,
  input  logic       step_i,
  input  logic       dir_i,
  output logic [7:0] val_o,
  output logic       cy_o
);

  always_comb begin
    val_o = val_i;
    cy_o  = 1'b0;
    if (step_i) begin
      if (dir_i) begin
        if (val_i == MAX) begin
          val_o = 8'h00;
          cy_o  = 1'b1;
        end else if (val_i[3:0] == BCD_DIGIT_MAX) begin
          val_o = {val_i[7:4] + 4'd1, 4'd0};
        end else begin
          val_o = {val_i[7:4], val_i[3:0] + 4'd1};
        end
      end else begin
        if (val_i == 8'h00) begin
          val_o = MAX;
          cy_o  = 1'b1;
        end else if (val_i[3:0] == 4'd0) begin
          val_o = {val_i[7:4] - 4'd1, BCD_DIGIT_MAX};
        end else begin
          val_o = {val_i[7:4], val_i[3:0] - 4'd1};
        end
      end
    end
  end

endmodule

// File: rtl/rcounter_bcd_timer.sv
// BCD min/sec/10ms up/down timer with 10 ms prescaler, load and time-out.
// Ports: clk_core, rst (async high), bus (slave modport of the timer if).
// RCOUNTER_AUTO_RELOAD_EN: reload and keep running instead of sticky DONE.
module rcounter_bcd_timer
  import rcounter_pkg::*;
#(
  parameter int         TICK_DIV = 500000,
  parameter logic [7:0] MIN_MAX  = 8'h59
) (
  input  logic                   clk_core,
  input  logic                   rst,
  rcounter_bcd_timer_if.slave    bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [23:0]   preset_q, preset_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          time_out_q, time_out_d;
  logic          load_err_q, load_err_d;

  logic [23:0] target;
  logic [23:0] reload;
  logic [23:0] stepped;
  logic        at_target;
  logic        tick;
  logic        preset_ok;
  logic        ms_cy, sec_cy, min_cy_unused;

  // Target and reload value both derive from the latched preset.
  assign target    = dir_q ? preset_q : 24'h0;
  assign reload    = dir_q ? 24'h0 : preset_q;
  assign at_target = (cnt_q == target);
  assign tick      = (state_q == RUN) && bus.en &&
                     !at_target && (presc_q == PMAX);

  assign preset_ok = bcd_pair_valid(bus.min_i, MIN_MAX) &&
                     bcd_pair_valid(bus.sec_i, BCD_SEC_MAX) &&
                     (bus.sec_i[7:4] <= BCD_TENS_SEC_MAX) &&
                     bcd_pair_valid(bus.ms_10_i, BCD_CENT_MAX);

  bcd_pair_step #(.MAX(BCD_CENT_MAX)) u_ms (
    .val_i  (cnt_q[7:0]),
    .step_i (tick),
    .dir_i  (dir_q),
    .val_o  (stepped[7:0]),
    .cy_o   (ms_cy)
  );

  bcd_pair_step #(.MAX(BCD_SEC_MAX)) u_sec (
    .val_i  (cnt_q[15:8]),
    .step_i (ms_cy),
    .dir_i  (dir_q),
    .val_o  (stepped[15:8]),
    .cy_o   (sec_cy)
  );

  bcd_pair_step #(.MAX(MIN_MAX)) u_min (
    .val_i  (cnt_q[23:16]),
    .step_i (sec_cy),
    .dir_i  (dir_q),
    .val_o  (stepped[23:16]),
    .cy_o   (min_cy_unused)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = stepped;
    preset_d   = preset_q;
    presc_d    = presc_q;
    dir_d      = dir_q;
    load_err_d = 1'b0;
`ifdef RCOUNTER_AUTO_RELOAD_EN
    time_out_d = 1'b0;
`else
    time_out_d = time_out_q;
`endif

    if ((state_q == RUN) && bus.en) begin
      presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
    end

    if ((state_q == RUN) && at_target) begin
`ifdef RCOUNTER_AUTO_RELOAD_EN
      cnt_d      = reload;
      time_out_d = 1'b1;
`else
      state_d    = DONE;
      time_out_d = 1'b1;
`endif
    end

    // A valid load overrides any tick or compare on the same edge.
    if (bus.load) begin
      if (preset_ok) begin
        preset_d   = {bus.min_i, bus.sec_i, bus.ms_10_i};
        dir_d      = bus.dir;
        cnt_d      = bus.dir ? 24'h0 : preset_d;
        presc_d    = '0;
        time_out_d = 1'b0;
        state_d    = RUN;
      end else begin
        cnt_d      = cnt_q;
        state_d    = state_q;
        time_out_d = time_out_q;
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      preset_q   <= '0;
      presc_q    <= '0;
      dir_q      <= 1'b0;
      time_out_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      preset_q   <= preset_d;
      presc_q    <= presc_d;
      dir_q      <= dir_d;
      time_out_q <= time_out_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.min_o    = cnt_q[23:16];
  assign bus.sec_o    = cnt_q[15:8];
  assign bus.ms_10_o  = cnt_q[7:0];
  assign bus.time_out = time_out_q;
  assign bus.load_err = load_err_q;
  assign bus.running  = (state_q == RUN) && bus.en;

endmodule
